mips32_prefetch_queue: RTL

MIPS32_PREFETCH_QUEUE -- requirements
Module: mips32_prefetch_queue

---
 rtl/mips32_prefetch_queue.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mips32_prefetch_queue.sv
// mips32_prefetch_queue
// Instruction prefetch queue that sits between a 1-cycle-latency instruction
// memory and the IF/ID pipeline register. It issues one word fetch per cycle
// while queue credit allows. Responses are buffered and presented at the head
// as {ir_out, npc_out}. A taken branch (redirect) flushes the queue and restarts
// fetch at the target. halt_in stops new fetches while the queue keeps draining.
//
// Optional feature: define PFQ_BYPASS_EN to forward a response that arrives
// while the queue is empty straight to the head outputs in the same cycle.
module mips32_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [AW-1:0]            imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic                     halt_in,
    output logic [31:0]              ir_out,
    output logic [31:0]              npc_out,
    output logic                     ir_valid,
    input  logic                     ir_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } entry_t;

    entry_t          queue_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;

    logic            credit;
    logic            resp_valid;
    logic            bypass;
    logic            push;
    logic            pop;
    entry_t          resp_entry;
    entry_t          out_entry;

    // Fetch issue: request only when the queue can absorb every word already in flight.
    always_comb begin
        credit    = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(DEPTH);
        imem_req  = !rst && !halt_in && !redirect_valid && credit;
        imem_addr = fetch_pc_q[AW-1:0];
    end

    // Response handling, head selection and the push/pop handshake.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        resp_valid       = inflight_q && !redirect_valid && !rst;
        resp_entry.ir    = imem_rdata;
        resp_entry.npc   = inflight_pc_q + 32'd1;
`ifdef PFQ_BYPASS_EN
        bypass           = resp_valid && (count_q == '0);
`else
        bypass           = 1'b0;
`endif
        ir_valid         = !rst && ((count_q != '0) || bypass);
        out_entry        = '0;
        if (bypass) begin
            out_entry = resp_entry;
        end else if (ir_valid) begin
            out_entry = queue_q[rd_ptr_q];
        end
        ir_out           = out_entry.ir;
        npc_out          = out_entry.npc;
        // A redirect discards any same-cycle handshake; a consumed bypass word is never stored.
        pop              = !rst && !redirect_valid && (count_q != '0) && ir_ready;
        push             = resp_valid && !(bypass && ir_ready);
        occupancy        = rst ? '0 : count_q;
    end

    // Next-state for fetch PC, in-flight tracking, queue pointers and count.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = imem_req;
        inflight_pc_d = imem_req ? fetch_pc_q : inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (imem_req) begin
                fetch_pc_d = fetch_pc_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
        if (push) begin
            queue_q[wr_ptr_q] <= resp_entry;
        end
    end

endmodule
